// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared panel geometry, width helpers and copy FSM encoding
package hub75_pkg;

    localparam int DEF_N_BANKS  = 2;
    localparam int DEF_N_ROWS   = 32;
    localparam int DEF_N_COLS   = 64;
    localparam int DEF_N_CHANS  = 3;
    localparam int DEF_N_PLANES = 8;

    localparam int DEF_LOG_N_BANKS = $clog2(DEF_N_BANKS);
    localparam int DEF_LOG_N_ROWS  = $clog2(DEF_N_ROWS);
    localparam int DEF_LOG_N_COLS  = $clog2(DEF_N_COLS);

    // Pixel width: every colour channel carries all of its bit planes.
    function automatic int pw_width(input int n_chans, input int n_planes);
        return n_chans * n_planes;
    endfunction

    // Frame memory address: {back_sel, bank, row, col}.
    function automatic int fa_width(input int log_banks, input int log_rows, input int log_cols);
        return 1 + log_banks + log_rows + log_cols;
    endfunction

    localparam int DEF_PW = pw_width(DEF_N_CHANS, DEF_N_PLANES);
    localparam int DEF_FA = fa_width(DEF_LOG_N_BANKS, DEF_LOG_N_ROWS, DEF_LOG_N_COLS);

    typedef enum logic [1:0] {
        FBW_IDLE  = 2'd0,
        FBW_COPY  = 2'd1,
        FBW_DRAIN = 2'd2
    } fbw_state_t;

endpackage

// File: rtl/hub75_fbw_sink_if.sv
// rtl/hub75_fbw_sink_if.sv - frame-buffer write interface between pattern generator and sink
interface hub75_fbw_sink_if
    import hub75_pkg::*;
#(
    parameter int LOG_N_BANKS = DEF_LOG_N_BANKS,
    parameter int LOG_N_ROWS  = DEF_LOG_N_ROWS,
    parameter int LOG_N_COLS  = DEF_LOG_N_COLS,
    parameter int PW          = DEF_PW
);

    logic [LOG_N_BANKS-1:0] fbw_bank_addr;
    logic [LOG_N_ROWS-1:0]  fbw_row_addr;
    logic                   fbw_row_store;
    logic                   fbw_row_rdy;
    logic                   fbw_row_swap;
    logic [PW-1:0]          fbw_data;
    logic [LOG_N_COLS-1:0]  fbw_col_addr;
    logic                   fbw_wren;
    logic                   frame_swap;
    logic                   frame_rdy;

    modport master (
        output fbw_bank_addr, fbw_row_addr, fbw_row_store, fbw_row_swap,
        output fbw_data, fbw_col_addr, fbw_wren, frame_swap,
        input  fbw_row_rdy, frame_rdy
    );

    modport slave (
        input  fbw_bank_addr, fbw_row_addr, fbw_row_store, fbw_row_swap,
        input  fbw_data, fbw_col_addr, fbw_wren, frame_swap,
        output fbw_row_rdy, frame_rdy
    );

endinterface

// File: rtl/hub75_fbw_linebuf.sv
// rtl/hub75_fbw_linebuf.sv - two-half line buffer, synchronous registered read
module hub75_fbw_linebuf
    import hub75_pkg::*;
#(
    parameter int N_COLS = DEF_N_COLS,
    parameter int PW     = DEF_PW,
    localparam int LOG_N_COLS = $clog2(N_COLS)
)(
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [LOG_N_COLS-1:0] wr_addr,
    input  logic [PW-1:0]         wr_data,
    input  logic                  rd_en,
    input  logic                  rd_sel,
    input  logic [LOG_N_COLS-1:0] rd_addr,
    output logic [PW-1:0]         rd_data
);

    // No reset on storage or read register so the array maps onto block RAM.
    logic [PW-1:0] mem [2*N_COLS];

    // Write port: the half select is the MSB of the RAM address.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_sel, wr_addr}] <= wr_data;
        end
    end

    // Read port: holding rd_en low keeps the last word on rd_data.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[{rd_sel, rd_addr}];
        end
    end

endmodule

// File: rtl/hub75_fbw_sink.sv
// rtl/hub75_fbw_sink.sv - line-buffered row copier and frame swapper; HUB75_FBW_OVERRUN_EN adds overrun status
module hub75_fbw_sink
    import hub75_pkg::*;
#(
    parameter int N_BANKS  = DEF_N_BANKS,
    parameter int N_ROWS   = DEF_N_ROWS,
    parameter int N_COLS   = DEF_N_COLS,
    parameter int N_CHANS  = DEF_N_CHANS,
    parameter int N_PLANES = DEF_N_PLANES,
    localparam int LOG_N_BANKS = $clog2(N_BANKS),
    localparam int LOG_N_ROWS  = $clog2(N_ROWS),
    localparam int LOG_N_COLS  = $clog2(N_COLS),
    localparam int PW          = pw_width(N_CHANS, N_PLANES),
    localparam int FA          = fa_width(LOG_N_BANKS, LOG_N_ROWS, LOG_N_COLS)
)(
    input  logic              clk,
    input  logic              rst_n,
    hub75_fbw_sink_if.slave   fbw,
    input  logic              disp_frame_end,
    output logic              fb_front_sel,
    output logic [FA-1:0]     fbm_addr,
    output logic [PW-1:0]     fbm_data,
    output logic              fbm_we,
    input  logic              fbm_stall
`ifdef HUB75_FBW_OVERRUN_EN
    ,
    output logic              ovr_flag,
    output logic [7:0]        ovr_cnt
`endif
);

    fbw_state_t state_q, state_d;

    logic                   wr_sel_q;
    logic                   rd_sel_q;
    logic [LOG_N_BANKS-1:0] bank_q;
    logic [LOG_N_ROWS-1:0]  row_q;
    logic [LOG_N_COLS-1:0]  col_q;
    logic [LOG_N_COLS-1:0]  col_b_q;
    logic                   valid_b_q;
    logic                   front_q;
    logic                   swap_pend_q;
    logic                   frame_rdy_q;
    logic                   fe_held_q;
    logic [PW-1:0]          lb_rd_data;

    logic adv;
    logic rd_en;
    logic store_ok;
    logic last_col;
    logic drain_done;
    logic do_swap;

    // A stalled write freezes the whole read pipeline, so nothing needs a skid buffer.
    assign adv        = ~(fbm_we & fbm_stall);
    assign store_ok   = (state_q == FBW_IDLE) & fbw.fbw_row_store;
    assign last_col   = (col_q == LOG_N_COLS'(N_COLS - 1));
    assign rd_en      = (state_q == FBW_COPY) & adv;
    assign drain_done = fbm_we & ~fbm_stall & ~valid_b_q;
    assign do_swap    = swap_pend_q & (disp_frame_end | fe_held_q) & (state_q == FBW_IDLE);

    assign fbw.fbw_row_rdy = (state_q == FBW_IDLE);
    assign fbw.frame_rdy   = frame_rdy_q;
    assign fb_front_sel    = front_q;

    hub75_fbw_linebuf #(
        .N_COLS (N_COLS),
        .PW     (PW)
    ) u_linebuf (
        .clk     (clk),
        .wr_en   (fbw.fbw_wren),
        .wr_sel  (wr_sel_q),
        .wr_addr (fbw.fbw_col_addr),
        .wr_data (fbw.fbw_data),
        .rd_en   (rd_en),
        .rd_sel  (rd_sel_q),
        .rd_addr (col_q),
        .rd_data (lb_rd_data)
    );

    // Copy FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FBW_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Copy FSM next state: stores are only taken in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FBW_IDLE:  if (fbw.fbw_row_store) state_d = FBW_COPY;
            FBW_COPY:  if (adv && last_col)   state_d = FBW_DRAIN;
            FBW_DRAIN: if (drain_done)        state_d = FBW_IDLE;
            default:                          state_d = FBW_IDLE;
        endcase
    end

    // Writer-side half select toggles on every row swap, busy or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel_q <= 1'b0;
        end else if (fbw.fbw_row_swap) begin
            wr_sel_q <= ~wr_sel_q;
        end
    end

    // Latch row target and read half at store time; step the read column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sel_q <= 1'b0;
            bank_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
        end else if (store_ok) begin
            rd_sel_q <= ~wr_sel_q;
            bank_q   <= fbw.fbw_bank_addr;
            row_q    <= fbw.fbw_row_addr;
            col_q    <= '0;
        end else if (rd_en) begin
            col_q    <= col_q + 1'b1;
        end
    end

    // Track which column the line-buffer read register currently holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_b_q <= 1'b0;
            col_b_q   <= '0;
        end else if (adv) begin
            valid_b_q <= (state_q == FBW_COPY);
            col_b_q   <= col_q;
        end
    end

    // Frame memory write register; held unchanged while the memory stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fbm_we   <= 1'b0;
            fbm_addr <= '0;
            fbm_data <= '0;
        end else if (adv) begin
            fbm_we <= valid_b_q;
            if (valid_b_q) begin
                fbm_addr <= {~front_q, bank_q, row_q, col_b_q};
                fbm_data <= lb_rd_data;
            end
        end
    end

    // Front/back swap: request is registered, then taken on a frame end in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_q     <= 1'b0;
            swap_pend_q <= 1'b0;
            frame_rdy_q <= 1'b1;
        end else if (do_swap) begin
            front_q     <= ~front_q;
            swap_pend_q <= 1'b0;
            frame_rdy_q <= 1'b1;
        end else if (fbw.frame_swap && !swap_pend_q) begin
            swap_pend_q <= 1'b1;
            frame_rdy_q <= 1'b0;
        end
    end

    // Remember a frame end that lands mid-copy so the swap happens once IDLE is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fe_held_q <= 1'b0;
        end else if (state_q == FBW_IDLE) begin
            fe_held_q <= 1'b0;
        end else if (disp_frame_end && swap_pend_q) begin
            fe_held_q <= 1'b1;
        end
    end

`ifdef HUB75_FBW_OVERRUN_EN
    logic ovr_event;

    assign ovr_event = (fbw.fbw_row_store & (state_q != FBW_IDLE)) |
                       (fbw.frame_swap & swap_pend_q);

    // Sticky overrun flag and saturating overrun counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_flag <= 1'b0;
            ovr_cnt  <= 8'd0;
        end else if (ovr_event) begin
            ovr_flag <= 1'b1;
            if (ovr_cnt != 8'hFF) begin
                ovr_cnt <= ovr_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hub75_fbw_sink.sv
// tb/tb_hub75_fbw_sink.sv - randomized self-checking bench for hub75_fbw_sink
module tb_hub75_fbw_sink;
    import hub75_pkg::*;

    localparam int NC  = DEF_N_COLS;
    localparam int LB  = DEF_LOG_N_BANKS;
    localparam int LR  = DEF_LOG_N_ROWS;
    localparam int LC  = DEF_LOG_N_COLS;
    localparam int PWD = DEF_PW;
    localparam int FAW = DEF_FA;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           disp_frame_end;
    logic           fb_front_sel;
    logic [FAW-1:0] fbm_addr;
    logic [PWD-1:0] fbm_data;
    logic           fbm_we;
    logic           fbm_stall;
`ifdef HUB75_FBW_OVERRUN_EN
    logic           ovr_flag;
    logic [7:0]     ovr_cnt;
`endif

    hub75_fbw_sink_if fbw_if ();

    hub75_fbw_sink dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fbw            (fbw_if),
        .disp_frame_end (disp_frame_end),
        .fb_front_sel   (fb_front_sel),
        .fbm_addr       (fbm_addr),
        .fbm_data       (fbm_data),
        .fbm_we         (fbm_we),
        .fbm_stall      (fbm_stall)
`ifdef HUB75_FBW_OVERRUN_EN
        ,
        .ovr_flag       (ovr_flag),
        .ovr_cnt        (ovr_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference state: line buffer image, writer half, front half, overrun events.
    logic [PWD-1:0] lb_m [2][NC];
    logic           wr_m;
    logic           front_m;
    int             ovr_m;
    int             n_checks;
    int             n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ovr();
`ifdef HUB75_FBW_OVERRUN_EN
        check("ovr_cnt", ovr_cnt, (ovr_m > 255) ? 255 : ovr_m);
        check("ovr_flag", ovr_flag, ovr_m != 0);
`endif
    endtask

    // mode 0: col*0x010101, 1: full random, 2: random subset of columns
    task automatic fill_row(input int mode);
        for (int c = 0; c < NC; c++) begin
            logic [PWD-1:0] d;
            if (mode == 0) d = PWD'(c * 32'h010101);
            else           d = PWD'($urandom);
            if (mode != 2 || $urandom_range(0, 3) != 0) begin
                fbw_if.fbw_wren     = 1'b1;
                fbw_if.fbw_col_addr = LC'(c);
                fbw_if.fbw_data     = d;
                lb_m[wr_m][c]       = d;
                step();
            end
        end
        fbw_if.fbw_wren = 1'b0;
    endtask

    task automatic pulse_row_swap();
        fbw_if.fbw_row_swap = 1'b1;
        step();
        fbw_if.fbw_row_swap = 1'b0;
        wr_m = ~wr_m;
    endtask

    // mode 0: no stall, 1: 3-cycle stall at column 10, 2: random stalls
    task automatic copy_row(input int bank, input int row, input int mode,
                            input bit dup, input bit fe_mid);
        logic [LB-1:0]  b;
        logic [LR-1:0]  r;
        logic           rd_h;
        logic [FAW-1:0] ea;
        logic [FAW-1:0] pa;
        logic [PWD-1:0] pd;
        logic [PWD-1:0] wd;
        logic           prev_st;
        int lowc, stalls, n, cyc, burst, wc;
        b = LB'(bank);
        r = LR'(row);
        rd_h = ~wr_m;
        lowc = 0; stalls = 0; n = 0; cyc = 0; burst = 0;
        prev_st = 1'b0; pa = '0; pd = '0;
        fbw_if.fbw_bank_addr = b;
        fbw_if.fbw_row_addr  = r;
        fbw_if.fbw_row_store = 1'b1;
        step();
        while (!fbw_if.fbw_row_rdy && cyc < 1000) begin
            lowc++;
            fbw_if.fbw_row_store = 1'b0;
            fbw_if.fbw_wren      = 1'b0;
            disp_frame_end       = 1'b0;
            if (prev_st) begin
                check("stall_hold_addr", fbm_addr, pa);
                check("stall_hold_data", fbm_data, pd);
            end
            if (fe_mid) check("front_during_copy", fb_front_sel, front_m);
            case (mode)
                1:       fbm_stall = fbm_we && (fbm_addr[LC-1:0] == LC'(10)) && (burst < 3);
                2:       fbm_stall = ($urandom_range(0, 3) == 0);
                default: fbm_stall = 1'b0;
            endcase
            if (mode == 1 && fbm_stall) burst++;
            if (fbm_we && fbm_stall) stalls++;
            if (fbm_we && !fbm_stall) begin
                ea = {~front_m, b, r, LC'(n)};
                check("fbm_addr", fbm_addr, ea);
                check("fbm_data", fbm_data, lb_m[rd_h][n % NC]);
                n++;
            end
            prev_st = fbm_we && fbm_stall;
            pa = fbm_addr;
            pd = fbm_data;
            if (dup && cyc == 20) begin
                fbw_if.fbw_row_store = 1'b1;
                ovr_m++;
            end
            if (fe_mid && cyc == 25) disp_frame_end = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                wc = $urandom_range(0, NC - 1);
                wd = PWD'($urandom);
                fbw_if.fbw_wren     = 1'b1;
                fbw_if.fbw_col_addr = LC'(wc);
                fbw_if.fbw_data     = wd;
                lb_m[wr_m][wc]      = wd;
            end
            step();
            cyc++;
        end
        fbm_stall            = 1'b0;
        fbw_if.fbw_row_store = 1'b0;
        fbw_if.fbw_wren      = 1'b0;
        disp_frame_end       = 1'b0;
        check("row_done", fbw_if.fbw_row_rdy, 1);
        check("row_writes", n, NC);
        check("rdy_low_cycles", lowc, NC + 2 + stalls);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  found;
        n_checks = 0; n_fail = 0;
        wr_m = 1'b0; front_m = 1'b0; ovr_m = 0;
        rst_n = 1'b0;
        disp_frame_end = 1'b0;
        fbm_stall = 1'b0;
        fbw_if.fbw_bank_addr = '0;
        fbw_if.fbw_row_addr  = '0;
        fbw_if.fbw_row_store = 1'b0;
        fbw_if.fbw_row_swap  = 1'b0;
        fbw_if.fbw_data      = '0;
        fbw_if.fbw_col_addr  = '0;
        fbw_if.fbw_wren      = 1'b0;
        fbw_if.frame_swap    = 1'b0;

        repeat (3) step();
        check("reset_row_rdy", fbw_if.fbw_row_rdy, 1);
        check("reset_frame_rdy", fbw_if.frame_rdy, 1);
        check("reset_front", fb_front_sel, 0);
        check("reset_fbm_we", fbm_we, 0);
        check("reset_fbm_addr", fbm_addr, 0);
        check("reset_fbm_data", fbm_data, 0);
        rst_n = 1'b1;
        step();
        check_ovr();

        fill_row(0);
        pulse_row_swap();
        copy_row(1, 5, 0, 1'b0, 1'b0);

        fill_row(1);
        pulse_row_swap();
        copy_row($urandom_range(0, 1), $urandom_range(0, 31), 1, 1'b0, 1'b0);

        fill_row(2);
        pulse_row_swap();
        copy_row($urandom_range(0, 1), $urandom_range(0, 31), 2, 1'b1, 1'b0);
        check_ovr();

        fbw_if.frame_swap = 1'b1;
        step();
        fbw_if.frame_swap = 1'b0;
        check("frame_rdy_drop", fbw_if.frame_rdy, 0);
        check("front_before_end", fb_front_sel, front_m);
        fbw_if.frame_swap = 1'b1;
        ovr_m++;
        step();
        fbw_if.frame_swap = 1'b0;
        step();
        check("frame_rdy_waiting", fbw_if.frame_rdy, 0);
        check("front_waiting", fb_front_sel, front_m);
        disp_frame_end = 1'b1;
        step();
        disp_frame_end = 1'b0;
        front_m = ~front_m;
        check("front_swapped", fb_front_sel, front_m);
        check("frame_rdy_up", fbw_if.frame_rdy, 1);
        check_ovr();

        fbw_if.frame_swap = 1'b1;
        disp_frame_end    = 1'b1;
        step();
        fbw_if.frame_swap = 1'b0;
        disp_frame_end    = 1'b0;
        check("same_cycle_front", fb_front_sel, front_m);
        check("same_cycle_rdy", fbw_if.frame_rdy, 0);
        step();
        disp_frame_end = 1'b1;
        step();
        disp_frame_end = 1'b0;
        front_m = ~front_m;
        check("next_end_front", fb_front_sel, front_m);
        check("next_end_rdy", fbw_if.frame_rdy, 1);

        fbw_if.frame_swap = 1'b1;
        step();
        fbw_if.frame_swap = 1'b0;
        fill_row(2);
        pulse_row_swap();
        copy_row($urandom_range(0, 1), $urandom_range(0, 31), 2, 1'b0, 1'b1);
        check("front_at_idle", fb_front_sel, front_m);
        step();
        front_m = ~front_m;
        check("front_after_idle", fb_front_sel, front_m);
        check("frame_rdy_after_idle", fbw_if.frame_rdy, 1);

        fill_row(1);
        pulse_row_swap();
        fbw_if.fbw_bank_addr = 1'b0;
        fbw_if.fbw_row_addr  = LR'(7);
        fbw_if.fbw_row_store = 1'b1;
        step();
        fbw_if.fbw_row_store = 1'b0;
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < 200) begin
            if (fbm_we && fbm_addr[LC-1:0] == LC'(30)) found = 1'b1;
            else begin
                step();
                cyc++;
            end
        end
        check("reached_col30", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_fbm_we", fbm_we, 0);
        check("abort_row_rdy", fbw_if.fbw_row_rdy, 1);
        step();
        check("abort_hold_we", fbm_we, 0);
        rst_n = 1'b1;
        wr_m = 1'b0; front_m = 1'b0; ovr_m = 0;
        step();
        check("post_rst_row_rdy", fbw_if.fbw_row_rdy, 1);
        check("post_rst_front", fb_front_sel, 0);
        check("post_rst_frame_rdy", fbw_if.frame_rdy, 1);
        check("post_rst_fbm_we", fbm_we, 0);
        check_ovr();
        fill_row(1);
        pulse_row_swap();
        copy_row($urandom_range(0, 1), $urandom_range(0, 31), 2, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hub75_fbw_sink.md
Name: hub75_fbw_sink

Overview:
- Responder end of the frame-buffer write interface that the pattern generator drives.
- Accepts per-column pixel writes into a double-buffered line buffer.
- On request, copies a completed row into the back half of a double-buffered frame memory.
- Manages the back/front frame swap, synchronised to the display scan's end-of-frame; sits between the pattern generator and the HUB75 scan engine's frame memory.

Parameters:
- N_BANKS, 2, panel banks driven in parallel
- N_ROWS, 32, rows per bank
- N_COLS, 64, columns per row
- N_CHANS, 3, colour channels
- N_PLANES, 8, bit planes per channel; pixel width PW = N_CHANS*N_PLANES
- Derived: LOG_N_BANKS, LOG_N_ROWS, LOG_N_COLS = $clog2 of each; FA = 1+LOG_N_BANKS+LOG_N_ROWS+LOG_N_COLS

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- fbw_bank_addr  in  LOG_N_BANKS  bank of the row being stored
- fbw_row_addr  in  LOG_N_ROWS  row being stored
- fbw_row_store  in  1  pulse: commit read-half line buffer to frame memory
- fbw_row_rdy  out  1  high when no copy is in progress
- fbw_row_swap  in  1  pulse: toggle line-buffer halves
- fbw_data  in  PW  pixel data
- fbw_col_addr  in  LOG_N_COLS  column of write
- fbw_wren  in  1  line-buffer write strobe
- frame_swap  in  1  pulse: request back/front swap
- frame_rdy  out  1  high when back frame may be written
- disp_frame_end  in  1  pulse from scan engine at end of displayed frame
- fb_front_sel  out  1  frame half the scan engine reads
- fbm_addr  out  FA  {back_sel, bank, row, col}
- fbm_data  out  PW  frame memory write data
- fbm_we  out  1  frame memory write strobe
- fbm_stall  in  1  memory busy; write not accepted this cycle

Behaviour:
- Reset values: fbw_row_rdy=1, frame_rdy=1, fb_front_sel=0, fbm_we=0, fbm_addr=0, fbm_data=0; line-buffer write half wr_sel=0; FSM in IDLE. Line-buffer contents are undefined after reset.
- Line buffer: 2 x N_COLS x PW. On fbw_wren, lb[wr_sel][fbw_col_addr] <= fbw_data. Writes are accepted in any state. fbw_row_swap toggles wr_sel at the clock edge.
- Swap during a copy: the copy keeps reading the half latched at store time (rd_sel captured on store).
- Copy FSM states: IDLE, COPY, DRAIN.
  - IDLE + fbw_row_store: latch bank/row, rd_sel=~wr_sel, col=0, fbw_row_rdy<=0, go to COPY.
  - COPY: issue line-buffer read at col. Read latency is 1 cycle; the data drives fbm_data/fbm_we on the next cycle.
  - While fbm_stall=1 with fbm_we=1: hold fbm_* stable and freeze col.
  - After the read at col=N_COLS-1 is issued, go to DRAIN.
  - DRAIN: wait for the last write to be accepted (fbm_we & ~fbm_stall), then go to IDLE with fbw_row_rdy<=1.
  - Unstalled, one row takes N_COLS+2 cycles from store to fbw_row_rdy=1.
- fbw_row_store while busy is ignored.
- fbm_addr back_sel = ~fb_front_sel.
- Frame swap:
  - frame_swap sets swap_pend and drops frame_rdy the next cycle.
  - On disp_frame_end with swap_pend=1 and FSM in IDLE: toggle fb_front_sel, clear swap_pend, raise frame_rdy.
  - disp_frame_end arriving while a copy is active is held in a 1-bit flag and honoured when the FSM next reaches IDLE.
  - frame_swap while swap_pend=1 is ignored.
  - frame_swap and disp_frame_end in the same cycle with no pending swap: the request is registered and the swap waits for the next disp_frame_end.
- Reset mid-copy aborts immediately; no further fbm_we.

Optional Feature:
- HUB75_FBW_OVERRUN_EN defined:
  - Adds outputs ovr_flag (1, sticky, cleared only by reset) and ovr_cnt (8 bits, saturating at 255).
  - Both increment/set on fbw_row_store while busy, or frame_swap while swap_pend.
- Undefined: ports absent; those events are silently ignored.

Decomposition:
- Shared package hub75_pkg: geometry localparams, FA/PW width helpers, FSM state encoding.
- One sub-module: hub75_fbw_linebuf, the 2-half synchronous-read RAM with registered read and separate write/read half select; it infers iCE40 BRAM.

Test Plan:
- Write cols 0..63 with data=col*0x010101, swap, store bank 1 row 5 -> 64 fbm_we with addr {1,1,5,col} and matching data; fbw_row_rdy low for exactly 66 cycles.
- Assert fbm_stall for 3 cycles at col 10 -> fbm_addr/data held stable; no column skipped or duplicated; row_rdy delayed by 3 cycles.
- Second fbw_row_store during copy -> ignored; exactly 64 writes; with OVERRUN_EN, ovr_cnt=1 and ovr_flag=1.
- frame_swap then disp_frame_end while idle -> fb_front_sel 0->1 one cycle after disp_frame_end; frame_rdy low in between.
- disp_frame_end mid-copy with swap pending -> swap occurs the cycle after the FSM returns to IDLE, not before.
- rst_n low at col 30 -> fbm_we=0 asynchronously; after release, row_rdy=1, fb_front_sel=0, and a fresh store completes normally.
